// File: rtl/mc_ctrl_if.sv
// Controller <-> datapath signal bundle for the multi-cycle MIPS core.
// The master side is the controller; the slave side is the datapath/bench.
interface mc_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic [5:0]       op;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;

    logic             pc_wr;
    logic             ir_wr;
    logic             reg_wr;
    logic             dm_wr;
    logic [1:0]       npc_op;
    logic [1:0]       reg_dst;
    logic             alu_src_b;
    logic [2:0]       alu_op;
    logic [1:0]       ext_op;
    logic [1:0]       wb_sel;
    logic [2:0]       state;
    logic             illegal;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        input  op, funct, zero, mem_ready,
        output pc_wr, ir_wr, reg_wr, dm_wr, npc_op, reg_dst, alu_src_b,
               alu_op, ext_op, wb_sel, state, illegal, instr_cnt
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  pc_wr, ir_wr, reg_wr, dm_wr, npc_op, reg_dst, alu_src_b,
               alu_op, ext_op, wb_sel, state, illegal, instr_cnt
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle main controller: sequences FETCH/DCD/EXE/MA/WB and drives
// datapath enables/selects as Mealy outputs of state, opcode/funct and zero.
module mc_ctrl_fsm #(
    parameter int unsigned CNT_W  = 32,
    parameter logic [1:0]  RA_SEL = 2'b10
) (
    input  logic      clk,
    input  logic      rst,
    mc_ctrl_if.master bus
);
    localparam int unsigned OP_W  = 6;
    localparam int unsigned SEL_W = 2;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_LUI   = 6'b001111;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;
    localparam logic [OP_W-1:0] OP_JAL   = 6'b000011;

    localparam logic [OP_W-1:0] FN_ADDU  = 6'b100001;
    localparam logic [OP_W-1:0] FN_SUBU  = 6'b100011;
    localparam logic [OP_W-1:0] FN_SLT   = 6'b101010;
    localparam logic [OP_W-1:0] FN_JR    = 6'b001000;

    localparam logic [SEL_W-1:0] NPC_PC4 = 2'b00;
    localparam logic [SEL_W-1:0] NPC_BR  = 2'b01;
    localparam logic [SEL_W-1:0] NPC_J   = 2'b10;
    localparam logic [SEL_W-1:0] NPC_JR  = 2'b11;

    localparam logic [SEL_W-1:0] DST_RT  = 2'b00;
    localparam logic [SEL_W-1:0] DST_RD  = 2'b01;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b011;
    localparam logic [ALU_W-1:0] ALU_LUI = 3'b100;

    localparam logic [SEL_W-1:0] EXT_ZERO  = 2'b00;
    localparam logic [SEL_W-1:0] EXT_SIGN  = 2'b01;
    localparam logic [SEL_W-1:0] EXT_UPPER = 2'b10;

    localparam logic [SEL_W-1:0] WB_ALU = 2'b00;
    localparam logic [SEL_W-1:0] WB_DM  = 2'b01;
    localparam logic [SEL_W-1:0] WB_PC4 = 2'b10;

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_DCD   = 3'd1,
        S_EXE   = 3'd2,
        S_MA    = 3'd3,
        S_WB    = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic             illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic is_r, is_addu, is_subu, is_slt, is_jr;
    logic is_ori, is_addi, is_lui, is_lw, is_sw, is_beq, is_j, is_jal;
    logic legal;

    logic [ALU_W-1:0] ins_alu_op;
    logic [SEL_W-1:0] ins_ext_op;
    logic             ins_src_b;

    // Instruction decode from the latched IR fields
    assign is_r    = (bus.op == OP_RTYPE);
    assign is_addu = is_r && (bus.funct == FN_ADDU);
    assign is_subu = is_r && (bus.funct == FN_SUBU);
    assign is_slt  = is_r && (bus.funct == FN_SLT);
    assign is_jr   = is_r && (bus.funct == FN_JR);
    assign is_ori  = (bus.op == OP_ORI);
    assign is_addi = (bus.op == OP_ADDI);
    assign is_lui  = (bus.op == OP_LUI);
    assign is_lw   = (bus.op == OP_LW);
    assign is_sw   = (bus.op == OP_SW);
    assign is_beq  = (bus.op == OP_BEQ);
    assign is_j    = (bus.op == OP_J);
    assign is_jal  = (bus.op == OP_JAL);

    assign legal = is_addu || is_subu || is_slt || is_jr || is_ori || is_addi ||
                   is_lui  || is_lw   || is_sw  || is_beq || is_j  || is_jal;

    // Per-instruction ALU/extender settings, applied in EXE, MA and WB
    always_comb begin : alu_decode
        ins_alu_op = ALU_ADD;
        ins_ext_op = EXT_ZERO;
        ins_src_b  = 1'b0;
        if (is_subu || is_beq) begin
            ins_alu_op = ALU_SUB;
        end else if (is_slt) begin
            ins_alu_op = ALU_SLT;
        end else if (is_ori) begin
            ins_alu_op = ALU_OR;
            ins_src_b  = 1'b1;
        end else if (is_lui) begin
            ins_alu_op = ALU_LUI;
            ins_ext_op = EXT_UPPER;
            ins_src_b  = 1'b1;
        end else if (is_addi || is_lw || is_sw) begin
            ins_ext_op = EXT_SIGN;
            ins_src_b  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin : state_reg
        if (!rst) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = S_DCD;
            S_DCD: begin
                if (!legal || is_j || is_jal) state_d = S_FETCH;
                else                          state_d = S_EXE;
            end
            S_EXE: begin
                if (is_beq || is_jr)     state_d = S_FETCH;
                else if (is_lw || is_sw) state_d = S_MA;
                else                     state_d = S_WB;
            end
            S_MA: begin
                if (bus.mem_ready) state_d = is_lw ? S_WB : S_FETCH;
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
        illegal_d = (state_q == S_DCD) && !legal;
        // Every return to FETCH retires one instruction, illegal ones included
        cnt_d = ((state_q != S_FETCH) && (state_d == S_FETCH)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // Mealy outputs; reset gates all enables and selects asynchronously
    always_comb begin : out_comb
        bus.pc_wr     = 1'b0;
        bus.ir_wr     = 1'b0;
        bus.reg_wr    = 1'b0;
        bus.dm_wr     = 1'b0;
        bus.npc_op    = NPC_PC4;
        bus.reg_dst   = DST_RT;
        bus.alu_src_b = 1'b0;
        bus.alu_op    = ALU_ADD;
        bus.ext_op    = EXT_ZERO;
        bus.wb_sel    = WB_ALU;
        if (rst) begin
            case (state_q)
                S_FETCH: begin
                    bus.pc_wr = 1'b1;
                    bus.ir_wr = 1'b1;
                end
                S_DCD: begin
                    if (is_j || is_jal) begin
                        bus.pc_wr  = 1'b1;
                        bus.npc_op = NPC_J;
                    end
                    if (is_jal) begin
                        bus.reg_wr  = 1'b1;
                        bus.reg_dst = RA_SEL;
                        bus.wb_sel  = WB_PC4;
                    end
                end
                S_EXE: begin
                    bus.alu_op    = ins_alu_op;
                    bus.ext_op    = ins_ext_op;
                    bus.alu_src_b = ins_src_b;
                    if (is_beq) begin
                        bus.pc_wr  = bus.zero;
                        bus.npc_op = NPC_BR;
                    end else if (is_jr) begin
                        bus.pc_wr  = 1'b1;
                        bus.npc_op = NPC_JR;
                    end
                end
                S_MA: begin
                    bus.alu_op    = ins_alu_op;
                    bus.ext_op    = ins_ext_op;
                    bus.alu_src_b = ins_src_b;
                    bus.dm_wr     = bus.mem_ready && is_sw;
                end
                S_WB: begin
                    bus.alu_op    = ins_alu_op;
                    bus.ext_op    = ins_ext_op;
                    bus.alu_src_b = ins_src_b;
                    bus.reg_wr    = 1'b1;
                    if (is_lw)     bus.wb_sel  = WB_DM;
                    else if (is_r) bus.reg_dst = DST_RD;
                end
                default: ;
            endcase
        end
    end

    assign bus.state     = state_q;
    assign bus.illegal   = illegal_q;
    assign bus.instr_cnt = cnt_q;

endmodule
